matinv_gj_seq: RTL and testbench



---
 rtl/matinv_pkg.sv | 24 ++
 rtl/matinv_gj_seq_if.sv | 31 +++
 rtl/matinv_mac.sv | 16 +
 rtl/matinv_gj_seq.sv | 235 +++++++++++++++++++++++
 tb/tb_matinv_gj_seq.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matinv_pkg.sv
// Shared types and constants for the sequential fraction-free Gauss-Jordan inverter.
// Pivot search/swap states are present only when MATINV_PIVOT_SWAP_EN is defined.
package matinv_pkg;

    localparam int MATINV_N  = 5;
    localparam int MATINV_W  = 16;
    localparam int MATINV_AW = 64;

`ifdef MATINV_PIVOT_SWAP_EN
    typedef enum logic [2:0] {
        ST_LOAD, ST_PIV, ST_SRCH, ST_SWAP, ST_ROWF, ST_UPD, ST_OUT
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_LOAD, ST_PIV, ST_ROWF, ST_UPD, ST_OUT
    } state_t;
`endif

    // Cycles from the last input acceptance to out_valid when no row swaps occur.
    function automatic int swapless_latency(input int n);
        return n * (1 + (n - 1) * (2 * n + 1)) + 1;
    endfunction

endpackage

// File: rtl/matinv_gj_seq_if.sv
// Load stream, result stream and busy flag of the matrix inverter.
// slave is the inverter side, master is the DMA/normaliser side.
interface matinv_gj_seq_if
    import matinv_pkg::*;
#(
    parameter int W  = MATINV_W,
    parameter int AW = MATINV_AW
) ();

    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [AW-1:0] out_data;
    logic [AW-1:0] out_pivot;
    logic          out_last;
    logic          out_singular;
    logic          out_ready;
    logic          busy;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_pivot, out_last, out_singular, busy
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_pivot, out_last, out_singular, busy
    );

endinterface

// File: rtl/matinv_mac.sv
// Shared row-update arithmetic: y = a*p - b*f, every term wrapping modulo 2^AW.
module matinv_mac
    import matinv_pkg::*;
#(
    parameter int AW = MATINV_AW
) (
    input  logic signed [AW-1:0] a,
    input  logic signed [AW-1:0] p,
    input  logic signed [AW-1:0] b,
    input  logic signed [AW-1:0] f,
    output logic signed [AW-1:0] y
);

    assign y = a * p - b * f;

endmodule

// File: rtl/matinv_gj_seq.sv
// Sequential fraction-free Gauss-Jordan inverter over [A | I], one element update per cycle.
// Optional MATINV_PIVOT_SWAP_EN adds zero-pivot row search and swap; otherwise a zero pivot flags singular.
//
// state | meaning
// LOAD  | accept N*N input elements row-major
// PIV   | latch pivot p = m[k][k]
// SRCH  | scan rows below k for a nonzero column-k entry (swap build only)
// SWAP  | exchange rows k and the found row (swap build only)
// ROWF  | latch row factor f = m[r][k]
// UPD   | m[r][c] <= m[r][c]*p - m[k][c]*f for c = 0..2N-1
// OUT   | stream right-half numerators with row pivots
module matinv_gj_seq
    import matinv_pkg::*;
#(
    parameter int N  = MATINV_N,
    parameter int W  = MATINV_W,
    parameter int AW = MATINV_AW
) (
    input  logic           clk,
    input  logic           rst,
    matinv_gj_seq_if.slave io
);

    localparam int RW = $clog2(N);
    localparam int CW = $clog2(2 * N);
    localparam logic [RW-1:0] R_LAST   = RW'(N - 1);
    localparam logic [CW-1:0] C_LAST_N = CW'(N - 1);
    localparam logic [CW-1:0] C_LAST_A = CW'(2 * N - 1);
    localparam logic [CW-1:0] C_RHS    = CW'(N);

    state_t state, state_n;

    logic signed [AW-1:0] m [N][2*N];
    logic [RW-1:0]        k, r;
    logic [CW-1:0]        c;
    logic signed [AW-1:0] p, f;
    logic                 singular;

    logic                 out_valid_q, out_last_q, out_sing_q;
    logic [AW-1:0]        out_data_q, out_pivot_q;

    logic signed [AW-1:0] in_ext, piv, elem_r, elem_k, upd_y;
    logic [RW-1:0]        first_r, last_r, next_r, nxt_or;
    logic [CW-1:0]        nxt_oc;
    logic                 row_done, at_last, frame_done;
    logic                 in_ready_c, busy_c, ld_fire, out_fire, enter_out, set_sing;

`ifdef MATINV_PIVOT_SWAP_EN
    logic [RW-1:0] s;
    logic          found;
    assign found = (m[s][CW'(k)] != '0);
`endif

    assign in_ext  = {{(AW - W){io.in_data[W-1]}}, io.in_data};
    assign piv     = m[k][CW'(k)];
    assign elem_r  = m[r][c];
    assign elem_k  = m[k][c];

    // Row walk order: ascending, skipping the pivot row.
    assign first_r  = (k == '0) ? RW'(1) : '0;
    assign last_r   = (k == R_LAST) ? RW'(N - 2) : R_LAST;
    assign next_r   = (r + RW'(1) == k) ? r + RW'(2) : r + RW'(1);
    assign row_done = (r == last_r);

    // r/c double as load position and as output beat position.
    assign at_last = (r == R_LAST) && (c == C_LAST_N);
    assign nxt_oc  = (c == C_LAST_N) ? '0 : c + CW'(1);
    assign nxt_or  = (c == C_LAST_N) ? r + RW'(1) : r;

    matinv_mac #(.AW(AW)) u_mac (
        .a (elem_r),
        .p (p),
        .b (elem_k),
        .f (f),
        .y (upd_y)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_LOAD;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_LOAD: if (io.in_valid && at_last) state_n = ST_PIV;
            ST_PIV: begin
                if (piv != '0) begin
                    state_n = ST_ROWF;
                end else begin
`ifdef MATINV_PIVOT_SWAP_EN
                    state_n = (k == R_LAST) ? ST_OUT : ST_SRCH;
`else
                    state_n = ST_OUT;
`endif
                end
            end
`ifdef MATINV_PIVOT_SWAP_EN
            ST_SRCH: begin
                if (found)             state_n = ST_SWAP;
                else if (s == R_LAST)  state_n = ST_OUT;
            end
            ST_SWAP: state_n = ST_PIV;
`endif
            ST_ROWF: state_n = ST_UPD;
            ST_UPD: begin
                if (c == C_LAST_A) begin
                    if (!row_done)          state_n = ST_ROWF;
                    else if (k == R_LAST)   state_n = ST_OUT;
                    else                    state_n = ST_PIV;
                end
            end
            ST_OUT: if (out_valid_q && io.out_ready && at_last) state_n = ST_LOAD;
            default: state_n = ST_LOAD;
        endcase
    end

    always_comb begin
        in_ready_c = (state == ST_LOAD) && !rst;
        busy_c     = (state != ST_LOAD) && !rst;
        ld_fire    = in_ready_c && io.in_valid;
        out_fire   = (state == ST_OUT) && out_valid_q && io.out_ready;
        frame_done = out_fire && at_last;
        enter_out  = (state != ST_OUT) && (state_n == ST_OUT);
        set_sing   = (state == ST_PIV) && (piv == '0);
`ifdef MATINV_PIVOT_SWAP_EN
        if ((state == ST_SRCH) && !found && (s == R_LAST)) set_sing = 1'b1;
`endif
    end

    // Reset and end-of-frame share one path: everything returns to the idle LOAD image.
    always_ff @(posedge clk) begin
        if (rst || frame_done) begin
            k           <= '0;
            r           <= '0;
            c           <= '0;
            p           <= '0;
            f           <= '0;
            singular    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_pivot_q <= '0;
            out_last_q  <= 1'b0;
            out_sing_q  <= 1'b0;
`ifdef MATINV_PIVOT_SWAP_EN
            s           <= '0;
`endif
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < 2 * N; j++) begin
                    m[RW'(i)][CW'(j)] <= (j == N + i) ? AW'(1) : '0;
                end
            end
        end else begin
            case (state)
                ST_LOAD: begin
                    if (ld_fire) begin
                        m[r][c] <= in_ext;
                        if (at_last) begin
                            r <= '0;
                            c <= '0;
                            k <= '0;
                        end else if (c == C_LAST_N) begin
                            r <= r + RW'(1);
                            c <= '0;
                        end else begin
                            c <= c + CW'(1);
                        end
                    end
                end
                ST_PIV: begin
                    p <= piv;
                    r <= first_r;
                    c <= '0;
`ifdef MATINV_PIVOT_SWAP_EN
                    s <= k + RW'(1);
`endif
                end
`ifdef MATINV_PIVOT_SWAP_EN
                ST_SRCH: if (!found) s <= s + RW'(1);
                ST_SWAP: begin
                    for (int j = 0; j < 2 * N; j++) begin
                        m[k][CW'(j)] <= m[s][CW'(j)];
                        m[s][CW'(j)] <= m[k][CW'(j)];
                    end
                end
`endif
                ST_ROWF: begin
                    f <= m[r][CW'(k)];
                    c <= '0;
                end
                ST_UPD: begin
                    m[r][c] <= upd_y;
                    if (c == C_LAST_A) begin
                        c <= '0;
                        if (!row_done)          r <= next_r;
                        else if (k != R_LAST)   k <= k + RW'(1);
                    end else begin
                        c <= c + CW'(1);
                    end
                end
                ST_OUT: begin
                    if (out_fire) begin
                        r           <= nxt_or;
                        c           <= nxt_oc;
                        out_data_q  <= m[nxt_or][C_RHS + nxt_oc];
                        out_pivot_q <= m[nxt_or][CW'(nxt_or)];
                        out_last_q  <= (nxt_or == R_LAST) && (nxt_oc == C_LAST_N);
                    end
                end
                default: ;
            endcase

            if (set_sing) singular <= 1'b1;

            if (enter_out) begin
                r           <= '0;
                c           <= '0;
                out_valid_q <= 1'b1;
                out_data_q  <= m[RW'(0)][C_RHS];
                out_pivot_q <= m[RW'(0)][CW'(0)];
                out_last_q  <= 1'b0;
                out_sing_q  <= singular | set_sing;
            end
        end
    end

    assign io.in_ready     = in_ready_c;
    assign io.busy         = busy_c;
    assign io.out_valid    = out_valid_q;
    assign io.out_data     = out_data_q;
    assign io.out_pivot    = out_pivot_q;
    assign io.out_last     = out_last_q;
    assign io.out_singular = out_sing_q;

endmodule

// File: tb/tb_matinv_gj_seq.sv
// Scoreboard bench for matinv_gj_seq: an N=5 and an N=2 instance fed directed matrices.
module tb_matinv_gj_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst5, rst2;

    matinv_gj_seq_if #(.W(16), .AW(64)) if5 ();
    matinv_gj_seq_if #(.W(16), .AW(64)) if2 ();

    matinv_gj_seq #(.N(5), .W(16), .AW(64)) u_dut5 (.clk(clk), .rst(rst5), .io(if5.slave));
    matinv_gj_seq #(.N(2), .W(16), .AW(64)) u_dut2 (.clk(clk), .rst(rst2), .io(if2.slave));

    typedef struct {
        logic [63:0] data;
        logic [63:0] pivot;
        logic        last;
        logic        sing;
        logic        chk_val;
    } beat_t;

    beat_t q5[$];
    beat_t q2[$];
    beat_t e5, e2;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc5 = 0, acc2 = 0;
    int lat5 = 0, lat2 = 0;
    bit rnd5 = 0, rnd2 = 0;
    int mat[64];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, $signed(got), $signed(exp));
        end
    endtask

    task automatic push(input int which, input longint d, input longint pv,
                        input bit last, input bit sing, input bit cv);
        beat_t b;
        b.data    = d;
        b.pivot   = pv;
        b.last    = last;
        b.sing    = sing;
        b.chk_val = cv;
        if (which == 5) q5.push_back(b);
        else            q2.push_back(b);
    endtask

    task automatic push2(input longint d0, input longint p0, input longint d1, input longint p1,
                         input longint d2, input longint p2, input longint d3, input longint p3,
                         input bit sing, input bit cv);
        push(2, d0, p0, 1'b0, sing, cv);
        push(2, d1, p1, 1'b0, sing, cv);
        push(2, d2, p2, 1'b0, sing, cv);
        push(2, d3, p3, 1'b1, sing, cv);
    endtask

    task automatic set2(input int a, input int b, input int c, input int d);
        mat[0] = a; mat[1] = b; mat[2] = c; mat[3] = d;
    endtask

    task automatic load(input int which, input int nn);
        int i;
        int guard;
        bit rdy;
        i = 0;
        guard = 0;
        while (i < nn * nn && guard < 500) begin
            @(negedge clk);
            if (which == 5) begin
                if5.in_valid = 1'b1;
                if5.in_data  = 16'(mat[i]);
                rdy          = if5.in_ready;
            end else begin
                if2.in_valid = 1'b1;
                if2.in_data  = 16'(mat[i]);
                rdy          = if2.in_ready;
            end
            if (rdy) begin
                if (which == 5) acc5 = cyc;
                else            acc2 = cyc;
                i++;
            end
            guard++;
        end
        if (i < nn * nn) begin
            n_cmp++;
            n_bad++;
            $display("FAIL load%0d_timeout: accepted %0d beats, want %0d", which, i, nn * nn);
        end
        @(negedge clk);
        if (which == 5) if5.in_valid = 1'b0;
        else            if2.in_valid = 1'b0;
    endtask

    task automatic drain(input int which, input int budget);
        bit done;
        done = 0;
        for (int t = 0; t < budget && !done; t++) begin
            @(negedge clk);
            if (which == 5) done = (q5.size() == 0) && !if5.out_valid;
            else            done = (q2.size() == 0) && !if2.out_valid;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain%0d_timeout: frame not finished after %0d cycles, want finished", which, budget);
            if (which == 5) q5.delete();
            else            q2.delete();
        end
    endtask

    // Output monitors: pick out_ready, check held fields while stalled, pop on acceptance.
    logic [63:0] hd5, hp5, hd2, hp2;
    logic        hl5, hs5, hl2, hs2;
    bit          stall5 = 0, pv5 = 0, stall2 = 0, pv2 = 0;

    always @(negedge clk) begin
        if (!rst5) begin
            if (stall5) begin
                chk("hold5_valid", 64'(if5.out_valid), 64'(1));
                chk("hold5_data", if5.out_data, hd5);
                chk("hold5_pivot", if5.out_pivot, hp5);
                chk("hold5_last", 64'(if5.out_last), 64'(hl5));
                chk("hold5_sing", 64'(if5.out_singular), 64'(hs5));
            end
            if (if5.out_valid && !pv5 && lat5 != 0) begin
                chk("latency5", 64'(cyc - acc5), 64'(lat5));
                lat5 = 0;
            end
            pv5 = if5.out_valid;
            if5.out_ready = rnd5 ? ($urandom_range(0, 1) == 1) : 1'b1;
            stall5 = if5.out_valid && !if5.out_ready;
            hd5 = if5.out_data;
            hp5 = if5.out_pivot;
            hl5 = if5.out_last;
            hs5 = if5.out_singular;
            if (if5.out_valid && if5.out_ready) begin
                if (q5.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL beat5_extra: got beat data %0d, want no beat", $signed(if5.out_data));
                end else begin
                    e5 = q5.pop_front();
                    if (e5.chk_val) begin
                        chk("beat5_data", if5.out_data, e5.data);
                        chk("beat5_pivot", if5.out_pivot, e5.pivot);
                    end
                    chk("beat5_last", 64'(if5.out_last), 64'(e5.last));
                    chk("beat5_sing", 64'(if5.out_singular), 64'(e5.sing));
                end
            end
        end else begin
            stall5 = 0;
            pv5 = 0;
            if5.out_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst2) begin
            if (stall2) begin
                chk("hold2_valid", 64'(if2.out_valid), 64'(1));
                chk("hold2_data", if2.out_data, hd2);
                chk("hold2_pivot", if2.out_pivot, hp2);
                chk("hold2_last", 64'(if2.out_last), 64'(hl2));
                chk("hold2_sing", 64'(if2.out_singular), 64'(hs2));
            end
            if (if2.out_valid && !pv2 && lat2 != 0) begin
                chk("latency2", 64'(cyc - acc2), 64'(lat2));
                lat2 = 0;
            end
            pv2 = if2.out_valid;
            if2.out_ready = rnd2 ? ($urandom_range(0, 1) == 1) : 1'b1;
            stall2 = if2.out_valid && !if2.out_ready;
            hd2 = if2.out_data;
            hp2 = if2.out_pivot;
            hl2 = if2.out_last;
            hs2 = if2.out_singular;
            if (if2.out_valid && if2.out_ready) begin
                if (q2.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL beat2_extra: got beat data %0d, want no beat", $signed(if2.out_data));
                end else begin
                    e2 = q2.pop_front();
                    if (e2.chk_val) begin
                        chk("beat2_data", if2.out_data, e2.data);
                        chk("beat2_pivot", if2.out_pivot, e2.pivot);
                    end
                    chk("beat2_last", 64'(if2.out_last), 64'(e2.last));
                    chk("beat2_sing", 64'(if2.out_singular), 64'(e2.sing));
                end
            end
        end else begin
            stall2 = 0;
            pv2 = 0;
            if2.out_ready = 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1);
    end

    initial begin
        rst5 = 1'b1;
        rst2 = 1'b1;
        if5.in_valid = 1'b0;
        if5.in_data  = '0;
        if2.in_valid = 1'b0;
        if2.in_data  = '0;

        repeat (2) @(negedge clk);
        chk("rst_in_ready5", 64'(if5.in_ready), 64'(0));
        chk("rst_in_ready2", 64'(if2.in_ready), 64'(0));
        rst5 = 1'b0;
        rst2 = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready5", 64'(if5.in_ready), 64'(1));
        chk("post_rst_busy5", 64'(if5.busy), 64'(0));
        chk("post_rst_out_valid5", 64'(if5.out_valid), 64'(0));
        chk("post_rst_out_data5", if5.out_data, 64'(0));
        chk("post_rst_out_pivot5", if5.out_pivot, 64'(0));
        chk("post_rst_out_last5", 64'(if5.out_last), 64'(0));
        chk("post_rst_out_sing5", 64'(if5.out_singular), 64'(0));
        chk("post_rst_in_ready2", 64'(if2.in_ready), 64'(1));
        chk("post_rst_busy2", 64'(if2.busy), 64'(0));

        // Identity N=5, free-running output, then again under random backpressure.
        for (int pass = 0; pass < 2; pass++) begin
            rnd5 = (pass == 1);
            for (int i = 0; i < 25; i++) begin
                mat[i] = (i / 5 == i % 5) ? 1 : 0;
                push(5, (i / 5 == i % 5) ? 1 : 0, 1, i == 24, 1'b0, 1'b1);
            end
            lat5 = 226;
            load(5, 5);
            chk("busy5_running", 64'(if5.busy), 64'(1));
            chk("in_ready5_running", 64'(if5.in_ready), 64'(0));
            drain(5, 3000);
        end
        rnd5 = 0;

        // [[2,1],[1,1]] -> numerators [[2,-2],[-1,2]], pivots 2 and 1.
        set2(2, 1, 1, 1);
        push2(2, 2, -2, 2, -1, 1, 2, 1, 1'b0, 1'b1);
        lat2 = 13;
        load(2, 2);
        drain(2, 200);

        // Rank-deficient matrix: zero pivot at k=1.
        set2(1, 2, 2, 4);
        push2(0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
`ifdef MATINV_PIVOT_SWAP_EN
        lat2 = 0;
`else
        lat2 = 8;
`endif
        load(2, 2);
        drain(2, 200);

        // Zero leading pivot: recoverable only by a row swap.
        set2(0, 1, 1, 0);
`ifdef MATINV_PIVOT_SWAP_EN
        push2(0, 1, 1, 1, 1, 1, 0, 1, 1'b0, 1'b1);
        lat2 = 0;
`else
        push2(0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
        lat2 = 2;
`endif
        load(2, 2);
        drain(2, 200);

        // Non-trivial matrix under random output backpressure.
        rnd2 = 1;
        set2(2, 1, 1, 1);
        push2(2, 2, -2, 2, -1, 1, 2, 1, 1'b0, 1'b1);
        lat2 = 13;
        load(2, 2);
        drain(2, 400);
        rnd2 = 0;

        // Abort during UPD, then a fresh load must still produce the right answer.
        lat2 = 0;
        set2(2, 1, 1, 1);
        load(2, 2);
        @(negedge clk);
        @(negedge clk);
        chk("midop_busy_before", 64'(if2.busy), 64'(1));
        rst2 = 1'b1;
        @(negedge clk);
        chk("midop_rst_in_ready", 64'(if2.in_ready), 64'(0));
        rst2 = 1'b0;
        @(negedge clk);
        chk("midop_busy_after", 64'(if2.busy), 64'(0));
        chk("midop_in_ready_after", 64'(if2.in_ready), 64'(1));
        chk("midop_out_valid_after", 64'(if2.out_valid), 64'(0));
        push2(2, 2, -2, 2, -1, 1, 2, 1, 1'b0, 1'b1);
        lat2 = 13;
        load(2, 2);
        drain(2, 200);

        repeat (3) @(negedge clk);
        chk("q5_empty", 64'(q5.size()), 64'(0));
        chk("q2_empty", 64'(q2.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
